// File: rtl/ccff_prog_pkg.sv
// Shared state encoding and word-size helper for the ccff chain programmer.
// Pure types/functions; no timing or flow-control of its own.
package ccff_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        ERR
    } state_e;

    // Bits taken from the next word: a full word, or whatever is left of the chain.
    function automatic int unsigned bits_in_word(input int unsigned remaining,
                                                 input int unsigned word_w);
        return (remaining < word_w) ? remaining : word_w;
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Packs serial ccff_tail samples (first sample -> bit0) into readback words; word out 1 cycle after
// its last sample, flush emits a zero-padded partial word. No backpressure: rb_valid is a pulse.
module ccff_rb_packer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic              sample_bit,
    input  logic              flush,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] acc_new;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;

    always_comb begin
        acc_new        = acc_q;
        acc_new[idx_q] = sample_bit;
        acc_d          = acc_q;
        idx_d          = idx_q;
        rb_data_d      = rb_data_q;
        rb_valid_d     = 1'b0;
        if (clear) begin
            acc_d = '0;
            idx_d = '0;
        end else if (sample_en) begin
            if (flush || (32'(idx_q) == WORD_W - 1)) begin
                rb_data_d  = acc_new;
                rb_valid_d = 1'b1;
                acc_d      = '0;
                idx_d      = '0;
            end else begin
                acc_d = acc_new;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            idx_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;

endmodule

// File: rtl/ccff_chain_programmer.sv
// Serialises bitstream words LSB-first into the ccff chain and returns the displaced bits as readback.
// WORD_W+1 cycles per word (accept then shifts); cfg_ready only in LOAD, so upstream gaps just stall.
module ccff_chain_programmer import ccff_prog_pkg::*; #(
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]   word_bits_q, word_bits_d;
    logic              last_q, last_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              load_start;
    int unsigned       rem;

    always_comb begin
        accept      = cfg_valid & cfg_ready_q;
        load_start  = 1'b0;
        rem         = CHAIN_LEN - 32'(bit_cnt_q);
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        word_bits_d = word_bits_q;
        last_d      = last_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    load_start  = 1'b1;
                    state_d     = LOAD;
                    bit_cnt_d   = '0;
                    word_bits_d = '0;
                    last_d      = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    // An early last word is rejected whole: nothing from it reaches the chain.
                    if (cfg_last && (rem > WORD_W)) begin
                        state_d = ERR;
                    end else begin
                        state_d     = SHIFT;
                        shift_reg_d = cfg_data;
                        word_bits_d = WB_W'(bits_in_word(rem, WORD_W));
                        last_d      = cfg_last;
                    end
                end
            end
            SHIFT: begin
                shift_reg_d = shift_reg_q >> 1;
                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                word_bits_d = word_bits_q - WB_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = last_q ? DONE : ERR;
                end else if (word_bits_q == WB_W'(1)) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        cfg_ready_d = (state_d == LOAD);
        shift_en_d  = (state_d == SHIFT);
        head_d      = shift_en_d & shift_reg_d[0];
        busy_d      = (state_d == LOAD) || (state_d == SHIFT);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            word_bits_q <= '0;
            last_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_bits_q <= word_bits_d;
            last_q      <= last_d;
            cfg_ready_q <= cfg_ready_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Tail is sampled on each shifting edge; the final chain bit forces out a partial word.
    ccff_rb_packer #(
        .WORD_W(WORD_W)
    ) u_rb_packer (
        .clk        (prog_clk),
        .rst_n      (pReset_n),
        .clear      (load_start),
        .sample_en  (shift_en_q),
        .sample_bit (ccff_tail),
        .flush      (shift_en_q && (bit_cnt_q == LAST_BIT)),
        .rb_data    (rb_data),
        .rb_valid   (rb_valid)
    );

    assign cfg_ready     = cfg_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
